// File: rtl/de_stage_pkg.sv
// Shared decode-stage definitions: latch widths, layout, op enumeration and RV32I opcodes.
package de_stage_pkg;

    localparam int FE_LATCH_WIDTH   = 129;
    localparam int AGEX_TO_DE_WIDTH = 7;
    localparam int MEM_TO_DE_WIDTH  = 7;
    localparam int WB_TO_DE_WIDTH   = 39;
    localparam int DE_LATCH_WIDTH   = 239;

    typedef enum logic [5:0] {
        OP_ILLEGAL = 6'd0,
        OP_LUI     = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
        OP_BEQ     = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,
        OP_BLTU    = 6'd9,  OP_BGEU  = 6'd10, OP_LW    = 6'd11, OP_SW    = 6'd12,
        OP_ADDI    = 6'd13, OP_SLTI  = 6'd14, OP_SLTIU = 6'd15, OP_XORI  = 6'd16,
        OP_ORI     = 6'd17, OP_ANDI  = 6'd18, OP_SLLI  = 6'd19, OP_SRLI  = 6'd20,
        OP_SRAI    = 6'd21, OP_ADD   = 6'd22, OP_SUB   = 6'd23, OP_SLL   = 6'd24,
        OP_SLT     = 6'd25, OP_SLTU  = 6'd26, OP_XOR   = 6'd27, OP_SRL   = 6'd28,
        OP_SRA     = 6'd29, OP_OR    = 6'd30, OP_AND   = 6'd31
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Field order is MSB first; the packed struct fixes every field offset.
    typedef struct packed {
        logic        valid;
        op_e         op;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcplus;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wr_reg;
        logic [31:0] inst_count;
    } de_latch_t;

    localparam int DE_FIELDS_WIDTH = $bits(de_latch_t);

    // A {valid, wr_reg, rd} producer that will eventually write register rs.
    function automatic logic producer_hit(input logic [6:0] producer, input logic [4:0] rs);
        return producer[6] && producer[5] && (producer[4:0] == rs);
    endfunction

endpackage

// File: rtl/de_stage_regfile.sv
// Architectural register file: two combinational read ports with same-cycle write bypass.
module regfile
    import de_stage_pkg::*;
#(
    parameter int DBITS    = 32,
    parameter int REGWORDS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [DBITS-1:0] rdata1,
    output logic [DBITS-1:0] rdata2,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [DBITS-1:0] wdata
);

    logic [DBITS-1:0] regs [REGWORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGWORDS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 always reads zero; a write landing this cycle is forwarded to the reader.
    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end

        rdata2 = regs[raddr2];
        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/de_stage.sv
// Decode stage: RV32I decode, register read, load-use style hazard stall and DE latch.
module de_stage
    import de_stage_pkg::*;
#(
    parameter int DBITS    = 32,
    parameter int INSTBITS = 32,
    parameter int REGWORDS = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [FE_LATCH_WIDTH-1:0]   from_FE_latch,
    input  logic [AGEX_TO_DE_WIDTH-1:0] from_AGEX_to_DE,
    input  logic [MEM_TO_DE_WIDTH-1:0]  from_MEM_to_DE,
    input  logic [WB_TO_DE_WIDTH-1:0]   from_WB_to_DE,
    input  logic                        from_AGEX_to_FE_flush,
    output logic                        from_DE_to_FE,
    output logic [DE_LATCH_WIDTH-1:0]   DE_latch_out
);

    logic                fe_valid;
    logic [INSTBITS-1:0] inst;
    logic [DBITS-1:0]    pc;
    logic [DBITS-1:0]    pcplus;
    logic [31:0]         inst_count;

    assign {fe_valid, inst, pc, pcplus, inst_count} = from_FE_latch;

    logic        wb_valid;
    logic        wb_wr_reg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    assign {wb_valid, wb_wr_reg, wb_rd, wb_data} = from_WB_to_DE;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    op_e         op;
    logic [31:0] imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        writes_rd;

    always_comb begin
        op        = OP_ILLEGAL;
        imm       = '0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_LUI:   begin op = OP_LUI;   imm = imm_u; writes_rd = 1'b1; end
            OPC_AUIPC: begin op = OP_AUIPC; imm = imm_u; writes_rd = 1'b1; end
            OPC_JAL:   begin op = OP_JAL;   imm = imm_j; writes_rd = 1'b1; end
            OPC_JALR: begin
                if (funct3 == 3'b000) op = OP_JALR;
                imm = imm_i; use_rs1 = 1'b1; writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_ILLEGAL;
                endcase
                imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) op = OP_LW;
                imm = imm_i; use_rs1 = 1'b1; writes_rd = 1'b1;
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) op = OP_SW;
                imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b000:  op = OP_ADDI;
                    3'b010:  op = OP_SLTI;
                    3'b011:  op = OP_SLTIU;
                    3'b100:  op = OP_XORI;
                    3'b110:  op = OP_ORI;
                    3'b111:  op = OP_ANDI;
                    3'b001:  op = (funct7 == 7'b0000000) ? OP_SLLI : OP_ILLEGAL;
                    default: op = (funct7 == 7'b0000000) ? OP_SRLI :
                                  (funct7 == 7'b0100000) ? OP_SRAI : OP_ILLEGAL;
                endcase
                imm = imm_i; use_rs1 = 1'b1; writes_rd = 1'b1;
            end
            OPC_OP: begin
                case ({funct7, funct3})
                    10'b0000000_000: op = OP_ADD;
                    10'b0100000_000: op = OP_SUB;
                    10'b0000000_001: op = OP_SLL;
                    10'b0000000_010: op = OP_SLT;
                    10'b0000000_011: op = OP_SLTU;
                    10'b0000000_100: op = OP_XOR;
                    10'b0000000_101: op = OP_SRL;
                    10'b0100000_101: op = OP_SRA;
                    10'b0000000_110: op = OP_OR;
                    10'b0000000_111: op = OP_AND;
                    default:         op = OP_ILLEGAL;
                endcase
                use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
            end
            default: op = OP_ILLEGAL;
        endcase
        // Illegal encodings neither read nor write registers, so they can never stall.
        if (op == OP_ILLEGAL) begin
            imm       = '0;
            use_rs1   = 1'b0;
            use_rs2   = 1'b0;
            writes_rd = 1'b0;
        end
    end

    logic [DBITS-1:0] rs1_val;
    logic [DBITS-1:0] rs2_val;

    regfile #(
        .DBITS    (DBITS),
        .REGWORDS (REGWORDS)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (wb_valid && wb_wr_reg),
        .waddr  (wb_rd),
        .wdata  (wb_data)
    );

    // WB producers are covered by the regfile bypass, so only AGEX and MEM can stall.
    logic raw_stall;

    always_comb begin
        raw_stall = fe_valid &&
            ((use_rs1 && (rs1 != 5'd0) &&
              (producer_hit(from_AGEX_to_DE, rs1) || producer_hit(from_MEM_to_DE, rs1))) ||
             (use_rs2 && (rs2 != 5'd0) &&
              (producer_hit(from_AGEX_to_DE, rs2) || producer_hit(from_MEM_to_DE, rs2))));
    end

    assign from_DE_to_FE = raw_stall && !from_AGEX_to_FE_flush && !reset;

    de_latch_t decoded;

    always_comb begin
        decoded            = '0;
        decoded.valid      = fe_valid;
        decoded.op         = op;
        decoded.inst       = inst;
        decoded.pc         = pc;
        decoded.pcplus     = pcplus;
        decoded.rs1_val    = rs1_val;
        decoded.rs2_val    = rs2_val;
        decoded.imm        = imm;
        decoded.rd         = rd;
        decoded.wr_reg     = writes_rd && (rd != 5'd0);
        decoded.inst_count = inst_count;
    end

    // Flush and stall both insert a bubble; a stalled instruction re-decodes once FE holds it.
    always_ff @(posedge clk) begin
        if (reset || from_AGEX_to_FE_flush || raw_stall) begin
            DE_latch_out <= '0;
        end else begin
            DE_latch_out <= {{(DE_LATCH_WIDTH - DE_FIELDS_WIDTH){1'b0}}, decoded};
        end
    end

endmodule

// File: tb/tb_de_stage.sv
// Directed bench for de_stage: per-cycle compare against a reference model plus literal checks.
module tb_de_stage;
    import de_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [128:0] fe;
    logic [6:0]   agex;
    logic [6:0]   mem;
    logic [38:0]  wb;
    logic         flush;
    logic         stall;
    logic [238:0] latch;

    int           checks = 0;
    int           errors = 0;
    logic         model_ready = 1'b0;
    logic [238:0] exp_latch = '0;
    logic [31:0]  model_regs [32];
    logic [31:0]  next_pc = 32'h0000_1000;
    logic [31:0]  next_count = 32'd1;

    de_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .from_FE_latch         (fe),
        .from_AGEX_to_DE       (agex),
        .from_MEM_to_DE        (mem),
        .from_WB_to_DE         (wb),
        .from_AGEX_to_FE_flush (flush),
        .from_DE_to_FE         (stall),
        .DE_latch_out          (latch)
    );

    always #5 clk = ~clk;

    // Reference decode written from the ISA tables rather than bit-by-bit.
    function automatic void ref_decode(input logic [31:0] inst, output logic [5:0] op,
                                       output logic [31:0] imm, output logic r1,
                                       output logic r2, output logic wr);
        logic [5:0]         btbl [8];
        logic [5:0]         itbl [8];
        logic [5:0]         rtbl [8];
        logic signed [31:0] s;
        logic [31:0]        top20, top25, sgn, ii, si, bi, ui, ji;
        logic [2:0]         f3;
        logic [6:0]         f7;
        btbl = '{OP_BEQ, OP_BNE, OP_ILLEGAL, OP_ILLEGAL, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
        itbl = '{OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI, OP_SRLI, OP_ORI, OP_ANDI};
        rtbl = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
        s     = inst;
        top20 = s >>> 20;
        top25 = s >>> 25;
        sgn   = s >>> 31;
        ii = top20;
        si = (top25 << 5) | 32'(inst[11:7]);
        bi = (sgn << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
        ui = inst & 32'hFFFF_F000;
        ji = (sgn << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
        f3 = inst[14:12];
        f7 = inst[31:25];
        op = OP_ILLEGAL; imm = '0; r1 = 1'b0; r2 = 1'b0; wr = 1'b0;
        case (inst[6:0])
            7'h37: begin op = OP_LUI;   imm = ui; wr = 1'b1; end
            7'h17: begin op = OP_AUIPC; imm = ui; wr = 1'b1; end
            7'h6F: begin op = OP_JAL;   imm = ji; wr = 1'b1; end
            7'h67: if (f3 == 3'd0) begin op = OP_JALR; imm = ii; r1 = 1'b1; wr = 1'b1; end
            7'h63: if (btbl[f3] != OP_ILLEGAL) begin op = btbl[f3]; imm = bi; r1 = 1'b1; r2 = 1'b1; end
            7'h03: if (f3 == 3'd2) begin op = OP_LW; imm = ii; r1 = 1'b1; wr = 1'b1; end
            7'h23: if (f3 == 3'd2) begin op = OP_SW; imm = si; r1 = 1'b1; r2 = 1'b1; end
            7'h13: begin
                if (!((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))) begin
                    op = (f3 == 3'd5 && f7 == 7'h20) ? OP_SRAI : itbl[f3];
                    imm = ii; r1 = 1'b1; wr = 1'b1;
                end
            end
            7'h33: begin
                if (f7 == 7'h00) op = rtbl[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) op = OP_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) op = OP_SRA;
                if (op != OP_ILLEGAL) begin r1 = 1'b1; r2 = 1'b1; wr = 1'b1; end
            end
            default: ;
        endcase
    endfunction

    function automatic logic busy(input logic [4:0] r);
        return (r != 5'd0) &&
               ((agex[6] && agex[5] && agex[4:0] == r) || (mem[6] && mem[5] && mem[4:0] == r));
    endfunction

    function automatic logic model_stall();
        logic [5:0]  op;
        logic [31:0] imm;
        logic        r1, r2, wr;
        ref_decode(fe[127:96], op, imm, r1, r2, wr);
        return fe[128] && !flush && !reset &&
               ((r1 && busy(fe[115:111])) || (r2 && busy(fe[120:116])));
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] r);
        if (r == 5'd0) return '0;
        if (wb[38] && wb[37] && wb[36:32] == r) return wb[31:0];
        return model_regs[r];
    endfunction

    // Model state advances on the same edge as the DUT, from the inputs held before it.
    always @(posedge clk) begin
        logic [5:0]  op;
        logic [31:0] imm, inst;
        logic        r1, r2, wr;
        if (reset) begin
            exp_latch = '0;
            for (int i = 0; i < 32; i++) model_regs[i] = '0;
            model_ready = 1'b1;
        end else begin
            inst = fe[127:96];
            ref_decode(inst, op, imm, r1, r2, wr);
            if (flush || model_stall())
                exp_latch = '0;
            else
                exp_latch = {2'b00, fe[128], op, inst, fe[95:64], fe[63:32],
                             read_reg(inst[19:15]), read_reg(inst[24:20]), imm,
                             inst[11:7], wr && (inst[11:7] != 5'd0), fe[31:0]};
            if (wb[38] && wb[37] && wb[36:32] != 5'd0) model_regs[wb[36:32]] = wb[31:0];
        end
    end

    always @(negedge clk) begin
        checks++;
        if (stall !== model_stall()) begin
            errors++;
            $display("[TB] FAIL model_stall at %0t: got %b expected %b", $time, stall, model_stall());
        end
        if (model_ready) begin
            checks++;
            if (latch !== exp_latch) begin
                errors++;
                $display("[TB] FAIL model_latch at %0t: got %h expected %h", $time, latch, exp_latch);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [238:0] actual, input logic [238:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] inst, input logic v, input logic [6:0] a,
                                 input logic [6:0] m, input logic [38:0] w, input logic fl);
        @(posedge clk);
        #2;
        fe    = {v, inst, next_pc, next_pc + 32'd4, next_count};
        agex  = a;
        mem   = m;
        wb    = w;
        flush = fl;
        next_pc    = next_pc + 32'd4;
        next_count = next_count + 32'd1;
    endtask

    localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;
    localparam logic [31:0] ADD_X2_X1   = 32'h0010_8133;
    localparam logic [31:0] ADD_X4_X3   = 32'h0001_8233;
    localparam logic [31:0] ADD_X4_X0   = 32'h0000_0233;
    localparam logic [31:0] LUI_X5      = 32'h1234_52B7;
    localparam logic [31:0] SW_X5_M4_X6 = 32'hFE53_2E23;
    localparam logic [31:0] JAL_X1_8    = 32'h0080_00EF;
    localparam logic [31:0] ILLEGAL     = 32'hFFFF_FFFF;

    logic [31:0] vectors [9];

    initial begin
        vectors = '{32'h0000_1097, 32'h0000_80E7, 32'hFE20_8CE3, 32'h0020_F463, 32'h0083_2283,
                    32'h4094_03B3, 32'h4030_D093, 32'h0000_0013, 32'h4000_0033};
        reset = 1'b1; fe = '0; agex = '0; mem = '0; wb = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_latch", latch, '0);
        checkOutput("reset_stall", 239'(stall), '0);
        @(posedge clk); #2; reset = 1'b0;

        applyStimulus(ADDI_X1_5, 1'b1, 7'h0, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("addi_stall", 239'(stall), '0);
        applyStimulus(ADD_X2_X1, 1'b1, {2'b11, 5'd1}, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("addi_valid", 239'(latch[236]), 239'(1));
        checkOutput("addi_op", 239'(latch[235:230]), 239'(OP_ADDI));
        checkOutput("addi_imm", 239'(latch[69:38]), 239'(5));
        checkOutput("addi_rd", 239'(latch[37:33]), 239'(1));
        checkOutput("addi_wr_reg", 239'(latch[32]), 239'(1));
        checkOutput("addi_rs1_val", 239'(latch[133:102]), '0);
        checkOutput("agex_hazard_stall", 239'(stall), 239'(1));

        applyStimulus(ADD_X2_X1, 1'b1, 7'h0, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("stall_bubble", latch, '0);
        checkOutput("agex_clear_stall", 239'(stall), '0);
        applyStimulus(ADDI_X1_5, 1'b1, {2'b11, 5'd5}, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("redecode_op", 239'(latch[235:230]), 239'(OP_ADD));
        checkOutput("unused_rs2_stall", 239'(stall), '0);
        applyStimulus(LUI_X5, 1'b1, {2'b11, 5'd8}, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("lui_no_rs_stall", 239'(stall), '0);
        applyStimulus(ADD_X2_X1, 1'b1, 7'h0, {2'b11, 5'd1}, '0, 1'b0);
        @(negedge clk);
        checkOutput("mem_hazard_stall", 239'(stall), 239'(1));
        applyStimulus(ADD_X2_X1, 1'b1, 7'h0, {2'b10, 5'd1}, '0, 1'b0);
        @(negedge clk);
        checkOutput("mem_nowrite_stall", 239'(stall), '0);

        applyStimulus(ADD_X4_X3, 1'b1, 7'h0, 7'h0, {2'b11, 5'd3, 32'hDEAD_BEEF}, 1'b0);
        @(negedge clk);
        checkOutput("wb_bypass_stall", 239'(stall), '0);
        applyStimulus(ADD_X2_X1, 1'b1, {2'b11, 5'd1}, 7'h0, '0, 1'b1);
        @(negedge clk);
        checkOutput("wb_bypass_rs1", 239'(latch[133:102]), 239'(32'hDEAD_BEEF));
        checkOutput("flush_stall", 239'(stall), '0);
        applyStimulus(ADD_X4_X0, 1'b1, 7'h0, 7'h0, {2'b11, 5'd0, 32'h0000_1234}, 1'b0);
        @(negedge clk);
        checkOutput("flush_latch", latch, '0);
        applyStimulus(ADD_X4_X0, 1'b1, 7'h0, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("x0_bypass_rs1", 239'(latch[133:102]), '0);
        applyStimulus(SW_X5_M4_X6, 1'b1, 7'h0, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("x0_read_rs1", 239'(latch[133:102]), '0);
        applyStimulus(JAL_X1_8, 1'b1, 7'h0, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("sw_imm", 239'(latch[69:38]), 239'(32'hFFFF_FFFC));
        checkOutput("sw_wr_reg", 239'(latch[32]), '0);
        applyStimulus(ILLEGAL, 1'b1, 7'h0, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("jal_imm", 239'(latch[69:38]), 239'(8));
        applyStimulus(ADD_X4_X3, 1'b1, 7'h0, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("illegal_op", 239'(latch[235:230]), 239'(OP_ILLEGAL));
        checkOutput("illegal_wr_reg", 239'(latch[32]), '0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i], 1'b1, 7'h0, 7'h0, '0, 1'b0);
        end

        applyStimulus(ADD_X2_X1, 1'b0, {2'b11, 5'd1}, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("invalid_fe_stall", 239'(stall), '0);
        applyStimulus(ADD_X2_X1, 1'b1, {2'b11, 5'd1}, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("invalid_fe_valid", 239'(latch[236]), '0);
        checkOutput("pre_reset_stall", 239'(stall), 239'(1));
        #1 reset = 1'b1;
        #1 checkOutput("reset_drops_stall", 239'(stall), '0);
        @(negedge clk);
        checkOutput("reset_mid_stall_latch", latch, '0);
        @(posedge clk); #2;
        reset = 1'b0;
        agex  = '0;
        applyStimulus(ADD_X4_X3, 1'b1, 7'h0, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_stall", 239'(stall), '0);
        applyStimulus(ADD_X4_X0, 1'b1, 7'h0, 7'h0, '0, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_x3", 239'(latch[133:102]), '0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/de_stage.md
DE_STAGE -- requirements
Module: de_stage

Interface
REQ-001 Parameter DBITS, default 32, data and PC width.
REQ-002 Parameter INSTBITS, default 32, instruction width.
REQ-003 Parameter REGWORDS, default 32, architectural register count; x0 is hardwired to zero.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 from_FE_latch  in  129  {valid, inst[31:0], PC[31:0], pcplus[31:0], inst_count[31:0]}, MSB first.
REQ-007 from_AGEX_to_DE  in  7  {valid, wr_reg, rd[4:0]} of the instruction in AGEX.
REQ-008 from_MEM_to_DE  in  7  {valid, wr_reg, rd[4:0]} of the instruction in MEM.
REQ-009 from_WB_to_DE  in  39  {valid, wr_reg, rd[4:0], wr_data[31:0]}; this is the register-file write port.
REQ-010 from_AGEX_to_FE_flush  in  1  branch mispredict in AGEX.
REQ-011 from_DE_to_FE  out  1  bit 0 is stall_pipe.
REQ-012 DE_latch_out  out  239  {valid, op[5:0], inst[31:0], PC[31:0], pcplus[31:0], rs1_val[31:0], rs2_val[31:0], imm[31:0], rd[4:0], wr_reg, inst_count[31:0]}, MSB first.

Function
REQ-013 Decode SHALL cover RV32I: LUI, AUIPC, JAL, JALR, BEQ–BGEU, LW, SW, the ALU-immediate and ALU-register classes, and an illegal opcode (op=ILLEGAL, wr_reg=0).
REQ-014 imm SHALL be the sign-extended I, S, B, U or J immediate selected by opcode, or 0 for R-type.
REQ-015 wr_reg SHALL be 1 only for instructions that write rd and only when rd≠0.
REQ-016 rs1_val and rs2_val SHALL be read combinationally from a 32x32 register file.
- x0 reads 0.
- WB→DE bypass: a same-cycle WB write to the register being read returns wr_data.
REQ-017 Register-file write occurs at the clock edge when WB valid&wr_reg and rd≠0; writes to x0 are ignored.
REQ-018 Hazard: stall_pipe=1 when the FE latch is valid and rs1 or rs2 (as used by op) is nonzero and equals rd of any valid, wr_reg=1 instruction in AGEX or MEM.
- A match with WB does not stall (bypass covers it).
- rs fields an op does not use SHALL NOT cause a stall.
REQ-019 stall_pipe SHALL be combinational, so FE holds in the same cycle.
REQ-020 On stall (no flush), DE_latch SHALL load a bubble (all zeros) so the stalled instruction re-decodes next cycle.
REQ-021 On flush, DE_latch SHALL load all zeros, and stall_pipe SHALL be forced to 0; flush has priority over stall.
REQ-022 Otherwise DE_latch SHALL load the decoded contents, with valid copied from the FE latch.
REQ-023 Latency: one cycle from FE latch to DE_latch_out.
REQ-024 An invalid FE latch SHALL produce valid=0 and SHALL NOT stall.
REQ-025 inst_count SHALL pass through unmodified; it is debug only.

Reset
REQ-026 While reset=1, DE_latch SHALL be all zeros and stall_pipe 0.
REQ-027 Register file contents SHALL clear to zero under reset.
REQ-028 Reset asserted mid-stall SHALL clear the stall and the latch at the next edge, with no pending state retained.

Structure
REQ-029 The op enumeration, latch widths, and field offsets SHALL live in the shared define.vh, next to FE_latch_WIDTH.
REQ-030 The register file SHALL be one sub-module, regfile (2 read ports, 1 write port, read bypass); decode and hazard logic stay in de_stage.

Verification
REQ-031 FE: ADDI x1,x0,5 (0x00500093), valid=1, no hazards → next cycle valid=1, op=ADDI, imm=5, rd=1, wr_reg=1, rs1_val=0.
REQ-032 AGEX: {1,1,rd=1}; FE: ADD x2,x1,x1 → stall_pipe=1 same cycle, DE_latch bubble; AGEX cleared → decoded next cycle.
REQ-033 WB writes x3=0xDEADBEEF while FE has ADD x4,x3,x0 → no stall, rs1_val=0xDEADBEEF.
REQ-034 Stall and flush in the same cycle → stall_pipe=0, DE_latch all zeros.
REQ-035 WB write to x0 of 0x1234, then read x0 → rs1_val=0; SW x5,-4(x6) → imm=0xFFFFFFFC, wr_reg=0.
REQ-036 Reset during a stall → DE_latch 0, stall_pipe 0 after one edge; all registers read 0.
